matmul_mem_master: RTL and testbench
====================================

# matmul_mem_master

Memory-side initiator for the matrix multiplier. It computes C = A x B for two N x N matrices of unsigned 8-bit elements. It reads A and B from the 8-bit synchronous data memory and writes C back into the same memory. It drives that memory's address, write-data, write-enable and read-enable lines and consumes its registered read data, which is valid one cycle after the read is sampled.

## Interface
Parameters:
- N, 4: matrix dimension; legal range 1..8.
- A_BASE, 0: byte address of A[0][0]; row-major.
- B_BASE, 64: byte address of B[0][0]; row-major.
- C_BASE, 128: byte address of C[0][0]; row-major.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE completes.
- done  out  1  one-cycle pulse in the DONE state.
- overflow  out  1  sticky; set if any C element exceeded 255 before truncation.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_rdata  in  8  memory read data, registered by the memory.

## Operation
- The FSM has states IDLE, RD_A, RD_B, MAC, WR and DONE. Indices i, j and k each run 0..N-1. The accumulator acc is 19 bits, enough for 8 x 255 x 255 with no loss.
- mem_addr, mem_wdata, mem_read and mem_write are combinational functions of the state and indices. They are 0 in IDLE and DONE.
- IDLE: busy=0. If start=1, clear i, j, k, acc and overflow, then go to RD_A. Otherwise stay.
- RD_A: mem_read=1, mem_addr=A_BASE+i*N+k. Go to RD_B.
- RD_B: mem_read=1, mem_addr=B_BASE+k*N+j. At the edge ending this state, latch a_reg=mem_rdata (the A element). Go to MAC.
- MAC: mem_rdata holds the B element; no memory access. At the edge, acc += a_reg*mem_rdata.
  - If k<N-1: k++, go to RD_A.
  - If k=N-1: k=0, go to WR.
- WR: mem_write=1, mem_addr=C_BASE+i*N+j, mem_wdata=acc[7:0]. At the edge:
  - If acc>255, set overflow.
  - Clear acc.
  - Advance j; when j wraps, advance i.
  - If i=N-1 and j=N-1, go to DONE. Otherwise go to RD_A.
- DONE: done=1, busy=1 for this one cycle. Go to IDLE.
- mem_read and mem_write are never high in the same cycle.
- start is ignored outside IDLE. A start that coincides with the DONE cycle is ignored.
- Address arithmetic is 16-bit with no wrap checking. The integrator keeps all regions inside the memory.

## Timing
- Reset values: state=IDLE, busy=0, done=0, overflow=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, internal counters and acc all 0.
- reset has priority over every other input. Asserting it mid-operation returns the block to IDLE at the next edge. No further memory accesses occur, C elements already written stay written, and overflow clears.
- Read latency is fixed:
  - The memory samples the RD_A request at the edge ending RD_A; its data is captured by this block at the edge ending RD_B.
  - The memory samples the RD_B request at the edge ending RD_B; its data is consumed at the edge ending MAC.
- One MAC step takes 3 cycles. One C element takes 3N+1 cycles.
- Counting the start-sampling edge as edge 0:
  - RD_A first occupies cycle 1.
  - The last WR occupies cycle N²(3N+1).
  - done is high in cycle N²(3N+1)+1.
  - busy is high from cycle 1 through the done cycle.
- A new start is accepted in the cycle immediately after done.

## Test plan
- Identity, N=2, A = [1,2;3,4], B = I, bases 0/64/128: memory 128..131 = 1,2,3,4; done in cycle 29; overflow=0.
- General product, N=2, A = [1,2;3,4], B = [5,6;7,8]: C = 19,22,43,50 at 128..131.
- Overflow, N=2, all A and B = 200: each C = 80000; write 80000 mod 256 = 128 to every C; overflow=1 after the first WR and remains set.
- Bus protocol check across a full N=4 run:
  - The address sequence matches the formulas.
  - mem_read and mem_write are never both high.
  - There are exactly 16 writes and 128 reads.
  - done is high for one cycle, in cycle 209.
- Reset mid-run, N=2: assert reset during the MAC of element (1,0):
  - The next cycle shows IDLE, with busy, done and overflow at 0.
  - Locations 130 and 131 are unchanged.
  - A new start completes correctly.
- Start while busy: pulse start in cycle 5 and in the done cycle; no restart occurs, and the result and timing match the undisturbed run.

Source files
------------

// File: rtl/matmul_mem_master.sv
// Memory-side initiator for the matrix multiplier: computes C = A x B over one
// shared 8-bit synchronous memory, one read pair per MAC step, one write per C element.
module matmul_mem_master #(
  parameter int N      = 4,
  parameter int A_BASE = 0,
  parameter int B_BASE = 64,
  parameter int C_BASE = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_e;

  localparam logic [2:0]  LAST = 3'(N - 1);
  localparam logic [15:0] NW   = 16'(N);

  state_e      state_q, state_d;
  logic [2:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [18:0] acc_q, acc_d;
  logic [7:0]  a_q, a_d;
  logic        ovf_q, ovf_d;
  logic [15:0] iW, jW, kW;

  assign iW       = {13'd0, i_q};
  assign jW       = {13'd0, j_q};
  assign kW       = {13'd0, k_q};
  assign overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      ovf_q   <= ovf_d;
    end
  end

  // RD_B captures the A element requested in RD_A; MAC consumes the B element.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_d     = a_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_d     = mem_rdata;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + 19'(a_q) * 19'(mem_rdata);
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = WR;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = RD_A;
        end
      end
      WR: begin
        if (acc_q > 19'd255) ovf_d = 1'b1;
        acc_d = '0;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = (i_q == LAST) ? 3'd0 : i_q + 3'd1;
        end else begin
          j_d = j_q + 3'd1;
        end
        state_d = (i_q == LAST && j_q == LAST) ? DONE : RD_A;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    unique case (state_q)
      RD_A: begin
        mem_read = 1'b1;
        mem_addr = 16'(A_BASE) + iW * NW + kW;
      end
      RD_B: begin
        mem_read = 1'b1;
        mem_addr = 16'(B_BASE) + kW * NW + jW;
      end
      WR: begin
        mem_write = 1'b1;
        mem_addr  = 16'(C_BASE) + iW * NW + jW;
        mem_wdata = acc_q[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_mem_master.sv
// Bench for matmul_mem_master: an N=2 and an N=4 instance, each on its own
// byte memory, checked against a matrix-level reference model and bus trace.
module tb_matmul_mem_master;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } access_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  start = 2'b00;
  logic [1:0]  busyV, doneV, ovfV, mRead, mWrite;
  logic [15:0] mAddr [2];
  logic [7:0]  mWdata [2];
  logic [7:0]  mRdata [2];

  logic [7:0]  mem [2][256];
  logic [7:0]  img [2][256];
  logic [1:0]  ldEn = 2'b00;
  logic [7:0]  ldAddr = 8'd0;
  logic [7:0]  ldData = 8'd0;

  access_t     expQ[$];
  int          active = 0;
  int          nRd = 0;
  int          nWr = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  matmul_mem_master #(.N(2)) u2 (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busyV[0]), .done(doneV[0]),
    .overflow(ovfV[0]), .mem_addr(mAddr[0]), .mem_wdata(mWdata[0]),
    .mem_write(mWrite[0]), .mem_read(mRead[0]), .mem_rdata(mRdata[0])
  );

  matmul_mem_master #(.N(4)) u4 (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busyV[1]), .done(doneV[1]),
    .overflow(ovfV[1]), .mem_addr(mAddr[1]), .mem_wdata(mWdata[1]),
    .mem_write(mWrite[1]), .mem_read(mRead[1]), .mem_rdata(mRdata[1])
  );

  // Synchronous memory with registered read data, plus a bench load port.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (ldEn[s]) mem[s][ldAddr] <= ldData;
      else if (mWrite[s]) mem[s][mAddr[s][7:0]] <= mWdata[s];
      if (mRead[s]) mRdata[s] <= mem[s][mAddr[s][7:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Every bus access must be the next one the reference model predicts.
  always @(negedge clk) begin
    access_t e;
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        if (mRead[s] || mWrite[s]) begin
          checkOutput("rd_wr_exclusive", {31'd0, mRead[s] & mWrite[s]}, 0);
          if (s != active || expQ.size() == 0) begin
            checkOutput("unexpected_access", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("access_kind", {31'd0, mWrite[s]}, {31'd0, e.wr});
            checkOutput("access_addr", {16'd0, mAddr[s]}, {16'd0, e.addr});
            if (e.wr) checkOutput("access_wdata", {24'd0, mWdata[s]}, {24'd0, e.data});
          end
          if (mRead[s]) nRd++;
          else nWr++;
        end
      end
    end
  end

  task automatic setByte(input int s, input int a, input logic [7:0] d);
    ldEn      = 2'b00;
    ldEn[s]   = 1'b1;
    ldAddr    = 8'(a);
    ldData    = d;
    img[s][a] = d;
    @(negedge clk);
    ldEn = 2'b00;
  endtask

  // kind: 0 A=seq,B=I  1 A=seq,B=seq+4  2 all 200  3 random small  4 random full
  task automatic applyStimulus(input int s, input int kind);
    int n;
    n = (s == 0) ? 2 : 4;
    for (int x = 0; x < n * n; x++) begin
      case (kind)
        0: begin
          setByte(s, x, 8'(x + 1));
          setByte(s, 64 + x, (x / n == x % n) ? 8'd1 : 8'd0);
        end
        1: begin
          setByte(s, x, 8'(x + 1));
          setByte(s, 64 + x, 8'(x + 5));
        end
        2: begin
          setByte(s, x, 8'd200);
          setByte(s, 64 + x, 8'd200);
        end
        3: begin
          setByte(s, x, 8'($urandom_range(0, 15)));
          setByte(s, 64 + x, 8'($urandom_range(0, 15)));
        end
        default: begin
          setByte(s, x, 8'($urandom_range(0, 255)));
          setByte(s, 64 + x, 8'($urandom_range(0, 255)));
        end
      endcase
      setByte(s, 128 + x, 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic runJob(input int s, input bit disturb, input int resetAt);
    int n, per, expDone, cyc, doneCyc, firstOvf, firstOvfExp, sum, abortElem;
    bit ovfExp;
    logic [7:0] cExp [64];
    access_t e;
    n = (s == 0) ? 2 : 4;
    per = 3 * n + 1;
    expDone = n * n * per + 1;
    expQ.delete();
    ovfExp = 1'b0;
    firstOvfExp = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        sum = 0;
        for (int k = 0; k < n; k++) begin
          e.wr = 1'b0; e.data = 8'd0;
          e.addr = 16'(i * n + k);
          expQ.push_back(e);
          e.addr = 16'(64 + k * n + j);
          expQ.push_back(e);
          sum += int'(img[s][i * n + k]) * int'(img[s][64 + k * n + j]);
        end
        e.wr = 1'b1; e.addr = 16'(128 + i * n + j); e.data = 8'(sum % 256);
        expQ.push_back(e);
        cExp[i * n + j] = 8'(sum % 256);
        if (sum > 255 && !ovfExp) begin
          ovfExp = 1'b1;
          firstOvfExp = (i * n + j + 1) * per + 1;
        end
      end
    end
    nRd = 0;
    nWr = 0;
    active = s;
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    cyc = 1;
    doneCyc = 0;
    firstOvf = 0;
    checkOutput("busy_cycle1", {31'd0, busyV[s]}, 1);
    while (cyc <= expDone + 20) begin
      if (ovfV[s] && firstOvf == 0) firstOvf = cyc;
      if (cyc == resetAt) break;
      if (doneV[s]) begin
        doneCyc = cyc;
        start[s] = disturb;
        break;
      end
      start[s] = disturb && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    if (resetAt != 0) begin
      checkOutput("ovf_before_reset", {31'd0, ovfV[s]},
                  {31'd0, ovfExp && resetAt >= firstOvfExp});
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expQ.delete();
      checkOutput("rst_busy", {31'd0, busyV[s]}, 0);
      checkOutput("rst_done", {31'd0, doneV[s]}, 0);
      checkOutput("rst_ovf", {31'd0, ovfV[s]}, 0);
      abortElem = (resetAt - 1) / per;
      for (int x = 0; x < n * n; x++) begin
        if (x < abortElem) checkOutput("rst_c_written", {24'd0, mem[s][128 + x]}, {24'd0, cExp[x]});
        else checkOutput("rst_c_kept", {24'd0, mem[s][128 + x]}, {24'd0, img[s][128 + x]});
      end
      for (int x = 0; x < abortElem; x++) img[s][128 + x] = cExp[x];
      repeat (3) @(negedge clk);
    end else begin
      checkOutput("done_cycle", doneCyc, expDone);
      checkOutput("busy_in_done", {31'd0, busyV[s]}, 1);
      @(negedge clk);
      start[s] = 1'b0;
      checkOutput("done_one_cycle", {31'd0, doneV[s]}, 0);
      checkOutput("busy_after_done", {31'd0, busyV[s]}, 0);
      @(negedge clk);
      checkOutput("no_restart", {31'd0, busyV[s]}, 0);
      checkOutput("ovf_final", {31'd0, ovfV[s]}, {31'd0, ovfExp});
      checkOutput("ovf_first_cycle", firstOvf, firstOvfExp);
      checkOutput("trace_complete", expQ.size(), 0);
      checkOutput("read_count", nRd, 2 * n * n * n);
      checkOutput("write_count", nWr, n * n);
      for (int x = 0; x < n * n; x++) begin
        checkOutput("c_value", {24'd0, mem[s][128 + x]}, {24'd0, cExp[x]});
        img[s][128 + x] = cExp[x];
      end
    end
  endtask

  initial begin
    logic [7:0] genC [4];
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_busy", {31'd0, busyV[s]}, 0);
      checkOutput("reset_done", {31'd0, doneV[s]}, 0);
      checkOutput("reset_ovf", {31'd0, ovfV[s]}, 0);
      checkOutput("reset_rd_wr", {30'd0, mRead[s], mWrite[s]}, 0);
      checkOutput("reset_addr", {16'd0, mAddr[s]}, 0);
      checkOutput("reset_wdata", {24'd0, mWdata[s]}, 0);
    end

    applyStimulus(0, 0);
    runJob(0, 1'b0, 0);
    for (int x = 0; x < 4; x++) checkOutput("ident_c", {24'd0, mem[0][128 + x]}, x + 1);

    genC[0] = 8'd19; genC[1] = 8'd22; genC[2] = 8'd43; genC[3] = 8'd50;
    applyStimulus(0, 1);
    runJob(0, 1'b1, 0);
    for (int x = 0; x < 4; x++) checkOutput("general_c", {24'd0, mem[0][128 + x]}, {24'd0, genC[x]});

    applyStimulus(0, 2);
    runJob(0, 1'b0, 0);
    for (int x = 0; x < 4; x++) checkOutput("ovf_c", {24'd0, mem[0][128 + x]}, 128);

    applyStimulus(0, 2);
    runJob(0, 1'b0, 17);
    applyStimulus(0, 1);
    runJob(0, 1'b0, 0);

    applyStimulus(1, 0);
    runJob(1, 1'b0, 0);
    applyStimulus(1, 3);
    runJob(1, 1'b1, 0);
    applyStimulus(1, 4);
    runJob(1, 1'b0, 0);
    applyStimulus(1, 3);
    runJob(1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
